// File: rtl/wt_duo_cache_pkg.sv
// Shared types and helpers for the dual WT / WT_CLN cache domain-switch logic.
package wt_duo_cache_pkg;

  typedef logic [1:0] priv_lvl_t;

  localparam priv_lvl_t PRIV_LVL_U = 2'b00;
  localparam priv_lvl_t PRIV_LVL_S = 2'b01;
  localparam priv_lvl_t PRIV_LVL_M = 2'b11;

  localparam int unsigned DefaultDrainTimeout = 1024;

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StFlush,
    StSwitch
  } switch_state_e;

  // M-mode traffic uses one cache flavour, every other level shares the other.
  function automatic logic is_m_domain(priv_lvl_t p);
    return p == PRIV_LVL_M;
  endfunction

endpackage

// File: rtl/wt_duo_cache_switch_ctrl.sv
// Sequences M <-> non-M cache domain changes: stall, drain write buffer, optional
// dcache flush, then switch the cache-facing privilege level.
module wt_duo_cache_switch_ctrl
  import wt_duo_cache_pkg::*;
#(
  parameter bit          FlushOnSwitch = 1'b1,
  parameter int unsigned DrainTimeout  = DefaultDrainTimeout,
  parameter int unsigned CntWidth      = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [1:0]          priv_lvl_i,
  input  logic                wbuffer_empty_i,
  input  logic                dcache_flush_ack_i,
  input  logic                flush_req_i,
  output logic                flush_ack_o,
  output logic                dcache_flush_o,
  output logic [1:0]          cache_priv_lvl_o,
  output logic                switch_stall_o,
  output logic                timeout_err_o,
  output logic [CntWidth-1:0] switch_cnt_o
);

  localparam int unsigned TmoW = (DrainTimeout == 0) ? 1 : $clog2(DrainTimeout + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'((DrainTimeout == 0) ? 0 : DrainTimeout - 1);

  switch_state_e       state_q, state_d;
  priv_lvl_t           cache_priv_q, cache_priv_d;
  priv_lvl_t           tgt_q, tgt_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;

  logic mism;
  logic tmo_fire;

  assign mism     = is_m_domain(priv_lvl_i) != is_m_domain(cache_priv_q);
  assign tmo_fire = (DrainTimeout != 0) && !wbuffer_empty_i && (tmo_q == TmoLast);

  always_comb begin
    state_d        = state_q;
    cache_priv_d   = cache_priv_q;
    tgt_d          = tgt_q;
    cnt_d          = cnt_q;
    tmo_d          = '0;
    switch_stall_o = 1'b0;
    dcache_flush_o = 1'b0;
    flush_ack_o    = 1'b0;
    timeout_err_o  = 1'b0;

    unique case (state_q)
      StIdle: begin
        switch_stall_o = mism;
        dcache_flush_o = flush_req_i;
        flush_ack_o    = dcache_flush_ack_i;
        if (!mism) begin
          cache_priv_d = priv_lvl_i;
        end else if (!flush_req_i) begin
          // A controller flush in flight finishes before the switch starts.
          tgt_d   = priv_lvl_i;
          state_d = StDrain;
        end
      end
      StDrain: begin
        switch_stall_o = 1'b1;
        timeout_err_o  = tmo_fire;
        tmo_d          = tmo_q + 1'b1;
        if (wbuffer_empty_i || tmo_fire) begin
          tmo_d   = '0;
          state_d = FlushOnSwitch ? StFlush : StSwitch;
        end
      end
      StFlush: begin
        switch_stall_o = 1'b1;
        dcache_flush_o = 1'b1;
        if (dcache_flush_ack_i) begin
          state_d = StSwitch;
        end
      end
      StSwitch: begin
        switch_stall_o = 1'b1;
        cache_priv_d   = tgt_q;
        if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cache_priv_q <= PRIV_LVL_M;
      tgt_q        <= PRIV_LVL_M;
      cnt_q        <= '0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      cache_priv_q <= cache_priv_d;
      tgt_q        <= tgt_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
    end
  end

  assign cache_priv_lvl_o = cache_priv_q;
  assign switch_cnt_o     = cnt_q;

endmodule

// File: tb/tb_wt_duo_cache_switch_ctrl.sv
// Scoreboard bench: three parameterisations share stimulus; a behavioural model predicts
// every cycle's outputs per instance and a negedge monitor compares.
module tb_wt_duo_cache_switch_ctrl;

  typedef struct packed {
    logic        stall;
    logic        dflush;
    logic        fack;
    logic        terr;
    logic [1:0]  cpriv;
    logic [15:0] cnt;
  } out_t;

  localparam int PhIdle   = 0;
  localparam int PhDrain  = 1;
  localparam int PhFlush  = 2;
  localparam int PhSwitch = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] priv;
  logic       wbe, ack, freq;

  logic        fack0, dfl0, cp_st0, terr0;
  logic        fack1, dfl1, cp_st1, terr1;
  logic        fack2, dfl2, cp_st2, terr2;
  logic [1:0]  cp0, cp1, cp2;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;
  logic [2:0]  cnt2;

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;
  int terr_seen[3];

  // Per-instance configuration: {FlushOnSwitch, DrainTimeout, counter max}
  int p_fos[3]  = '{1, 1, 0};
  int p_dt[3]   = '{1024, 4, 0};
  int p_cmax[3] = '{65535, 15, 7};

  int         m_ph[3];
  logic [1:0] m_cp[3];
  logic [1:0] m_tgt[3];
  int         m_cnt[3];
  int         m_age[3];

  out_t exp_q[3][$];
  out_t act[3];
  out_t mon_e;

  wt_duo_cache_switch_ctrl u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .priv_lvl_i(priv), .wbuffer_empty_i(wbe),
    .dcache_flush_ack_i(ack), .flush_req_i(freq), .flush_ack_o(fack0),
    .dcache_flush_o(dfl0), .cache_priv_lvl_o(cp0), .switch_stall_o(cp_st0),
    .timeout_err_o(terr0), .switch_cnt_o(cnt0)
  );

  wt_duo_cache_switch_ctrl #(.FlushOnSwitch(1'b1), .DrainTimeout(4), .CntWidth(4)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .priv_lvl_i(priv), .wbuffer_empty_i(wbe),
    .dcache_flush_ack_i(ack), .flush_req_i(freq), .flush_ack_o(fack1),
    .dcache_flush_o(dfl1), .cache_priv_lvl_o(cp1), .switch_stall_o(cp_st1),
    .timeout_err_o(terr1), .switch_cnt_o(cnt1)
  );

  wt_duo_cache_switch_ctrl #(.FlushOnSwitch(1'b0), .DrainTimeout(0), .CntWidth(3)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .priv_lvl_i(priv), .wbuffer_empty_i(wbe),
    .dcache_flush_ack_i(ack), .flush_req_i(freq), .flush_ack_o(fack2),
    .dcache_flush_o(dfl2), .cache_priv_lvl_o(cp2), .switch_stall_o(cp_st2),
    .timeout_err_o(terr2), .switch_cnt_o(cnt2)
  );

  initial forever #5 clk = ~clk;

  always_comb begin
    act[0] = '{stall: cp_st0, dflush: dfl0, fack: fack0, terr: terr0, cpriv: cp0, cnt: cnt0};
    act[1] = '{stall: cp_st1, dflush: dfl1, fack: fack1, terr: terr1, cpriv: cp1,
               cnt: 16'(cnt1)};
    act[2] = '{stall: cp_st2, dflush: dfl2, fack: fack2, terr: terr2, cpriv: cp2,
               cnt: 16'(cnt2)};
  end

  // Monitor: one expected record per instance per cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (exp_q[i].size() > 0) begin
        mon_e = exp_q[i].pop_front();
        checks++;
        if (act[i] !== mon_e) begin
          failures++;
          $display("FAIL inst%0d_cycle%0d {stall,dflush,fack,terr,cpriv,cnt} act=%b,%b,%b,%b,%0d,%0d exp=%b,%b,%b,%b,%0d,%0d",
                   i, cyc_n, act[i].stall, act[i].dflush, act[i].fack, act[i].terr,
                   act[i].cpriv, act[i].cnt, mon_e.stall, mon_e.dflush, mon_e.fack,
                   mon_e.terr, mon_e.cpriv, mon_e.cnt);
        end
        if (act[i].terr === 1'b1) terr_seen[i]++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", name, a, e);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_ph[i] = PhIdle; m_cp[i] = 2'd3; m_tgt[i] = 2'd3; m_cnt[i] = 0; m_age[i] = 0;
    end
  endtask

  // Predict this cycle's outputs from the current inputs, then advance the model.
  task automatic model_cycle();
    for (int i = 0; i < 3; i++) begin
      out_t e;
      bit   mism, fire;
      mism = (priv == 2'd3) != (m_cp[i] == 2'd3);
      fire = (m_ph[i] == PhDrain) && (p_dt[i] != 0) && !wbe && (m_age[i] == p_dt[i] - 1);
      e = '0;
      e.cpriv = m_cp[i];
      e.cnt   = 16'(m_cnt[i]);
      case (m_ph[i])
        PhIdle:  begin e.stall = mism; e.dflush = freq; e.fack = ack; end
        PhDrain: begin e.stall = 1'b1; e.terr = fire; end
        PhFlush: begin e.stall = 1'b1; e.dflush = 1'b1; end
        default: e.stall = 1'b1;
      endcase
      exp_q[i].push_back(e);

      if (!rst_n) begin
        m_ph[i] = PhIdle; m_cp[i] = 2'd3; m_cnt[i] = 0; m_age[i] = 0;
      end else begin
        case (m_ph[i])
          PhIdle: begin
            if (!mism) m_cp[i] = priv;
            else if (!freq) begin
              m_tgt[i] = priv; m_ph[i] = PhDrain; m_age[i] = 0;
            end
          end
          PhDrain: begin
            if (wbe || fire) begin
              m_age[i] = 0;
              m_ph[i]  = (p_fos[i] != 0) ? PhFlush : PhSwitch;
            end else m_age[i]++;
          end
          PhFlush: if (ack) m_ph[i] = PhSwitch;
          default: begin
            m_cp[i] = m_tgt[i];
            if (m_cnt[i] < p_cmax[i]) m_cnt[i]++;
            m_ph[i] = PhIdle;
          end
        endcase
      end
    end
  endtask

  task automatic cyc();
    model_cycle();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  initial begin
    rst_n = 1'b0; priv = 2'd3; wbe = 1'b1; ack = 1'b0; freq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    chk("reset_cache_priv", 32'(cp0), 32'd3);
    chk("reset_cnt", 32'(cnt0), 32'd0);
    chk("reset_stall", 32'(cp_st0), 32'd0);

    // M -> S, flush acked one cycle after it asserts
    priv = 2'd1; wbe = 1'b1;
    for (int c = 0; c < 5; c++) begin
      ack = (c == 3);
      cyc();
    end
    ack = 1'b0;
    chk("m2s_cache_priv", 32'(cp0), 32'd1);
    chk("m2s_cnt", 32'(cnt0), 32'd1);

    // S -> U: same domain, no stall
    priv = 2'd0;
    cyc();
    chk("s2u_cache_priv", 32'(cp0), 32'd0);
    chk("s2u_cnt", 32'(cnt0), 32'd1);

    // Back to M, then M -> S with write buffer busy for 10 cycles
    priv = 2'd3; ack = 1'b1;
    repeat (6) cyc();
    priv = 2'd1; wbe = 1'b0;
    repeat (11) cyc();
    wbe = 1'b1;
    repeat (8) cyc();
    chk("drain_no_timeout_default", 32'(terr_seen[0]), 32'd0);
    chk("drain_timeout_once_dt4", 32'(terr_seen[1]), 32'd1);
    chk("drain_cache_priv", 32'(cp0), 32'd1);

    // Controller flush passthrough in IDLE
    ack = 1'b0; freq = 1'b1;
    repeat (2) cyc();
    ack = 1'b1;
    #1;
    chk("pass_dflush", 32'(dfl0), 32'd1);
    chk("pass_fack", 32'(fack0), 32'd1);
    cyc();
    ack = 1'b0; freq = 1'b0;
    cyc();

    // Domain change while the controller flush is outstanding
    freq = 1'b1; priv = 2'd3;
    for (int c = 0; c < 6; c++) begin
      ack = (c == 2);
      cyc();
    end
    ack = 1'b0;
    #1;
    chk("held_stall", 32'(cp_st0), 32'd1);
    chk("held_cache_priv", 32'(cp0), 32'd1);
    freq = 1'b0;
    for (int c = 0; c < 8; c++) begin
      ack = (c >= 3);
      cyc();
    end
    chk("held_then_switch", 32'(cp0), 32'd3);

    // M -> S reversed back to M during FLUSH
    ack = 1'b0;
    for (int c = 0; c < 14; c++) begin
      priv = (c < 2) ? 2'd1 : 2'd3;
      ack  = (c >= 3);
      cyc();
    end
    chk("reverse_cache_priv", 32'(cp0), 32'd3);

    // Reset asserted while in FLUSH
    priv = 2'd1; ack = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    chk("rst_flush_cache_priv", 32'(cp0), 32'd3);
    chk("rst_flush_dflush", 32'(dfl0), 32'd0);
    chk("rst_flush_cnt", 32'(cnt0), 32'd0);
    ack = 1'b1;
    repeat (6) cyc();

    // Saturation of the narrow counters
    for (int k = 0; k < 20; k++) begin
      priv = (k % 2 == 0) ? 2'd3 : 2'd1;
      repeat (5) cyc();
    end
    chk("sat_cnt_w4", 32'(cnt1), 32'd15);
    chk("sat_cnt_w3", 32'(cnt2), 32'd7);

    // Randomised traffic
    for (int n = 0; n < 2000; n++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 7) == 0) priv = 2'($urandom_range(0, 3));
      wbe  = ($urandom_range(0, 3) != 0);
      ack  = ($urandom_range(0, 2) == 0);
      freq = ($urandom_range(0, 7) == 0);
      cyc();
    end

    rst_n = 1'b1;
    repeat (2) cyc();
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
